icache_assoc: RTL

//  Parametrised N-way set-associative instruction cache; successor to the direct-mapped icache.

---
 rtl/icache_assoc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: zero-latency lookup, round-robin fill
// replacement per set, and a multi-cycle flush walk that invalidates every set.

module icache_way #(
    parameter int SETS  = 256,
    parameter int IDX_W = 8,
    parameter int TAG_W = 23
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_match,
    output logic [31:0]      rd_inst,
    output logic             rd_is_c,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             wr_match,
    output logic             wr_valid,
    input  logic             we,
    input  logic [31:0]      wr_inst,
    input  logic             wr_is_c,
    input  logic             clr,
    input  logic [IDX_W-1:0] clr_idx
);
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];
    logic             c_mem    [SETS];

    assign rd_match = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_inst  = data_mem[rd_idx];
    assign rd_is_c  = c_mem[rd_idx];
    assign wr_valid = valid[wr_idx];
    assign wr_match = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid <= '0;
        end else if (clr) begin
            valid[clr_idx] <= 1'b0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_inst;
            c_mem[wr_idx]    <= wr_is_c;
        end
    end
endmodule

module icache_assoc #(
    parameter int SETS = 256,
    parameter int WAYS = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        icache_get_ready,
    input  logic [31:0] icache_get_addr,
    output logic        hit,
    output logic [31:0] icache_get_inst,
    output logic        icache_get_is_c,
    input  logic        wr_ready,
    input  logic        wr_is_c,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_inst,
    input  logic        flush_in,
    output logic        flush_busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 31 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           cnt;
    logic [SETS-1:0][WAY_W-1:0] rr_ptr;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             fill_en, clr, q_en, use_rr;
    logic [WAY_W-1:0] victim;

    logic [WAYS-1:0]        rd_match, wr_match, wr_valid, way_we, hit_vec, rd_is_c;
    logic [WAYS-1:0][31:0]  rd_inst;

    logic unused_addr_bits;
    assign unused_addr_bits = icache_get_addr[0] ^ wr_addr[0];

    assign rd_idx  = icache_get_addr[IDX_W:1];
    assign rd_tag  = icache_get_addr[31:IDX_W+1];
    assign wr_idx  = wr_addr[IDX_W:1];
    assign wr_tag  = wr_addr[31:IDX_W+1];

    assign flush_busy = (state == FLUSH);
    assign fill_en    = rdy_in && wr_ready && (state == IDLE) && !flush_in;
    assign clr        = rdy_in && (state == FLUSH);
    assign q_en       = icache_get_ready && !flush_busy;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS (SETS),
            .IDX_W(IDX_W),
            .TAG_W(TAG_W)
        ) u_way (
            .clk_in  (clk_in),
            .rst_n_in(rst_n_in),
            .rd_idx  (rd_idx),
            .rd_tag  (rd_tag),
            .rd_match(rd_match[w]),
            .rd_inst (rd_inst[w]),
            .rd_is_c (rd_is_c[w]),
            .wr_idx  (wr_idx),
            .wr_tag  (wr_tag),
            .wr_match(wr_match[w]),
            .wr_valid(wr_valid[w]),
            .we      (way_we[w]),
            .wr_inst (wr_inst),
            .wr_is_c (wr_is_c),
            .clr     (clr),
            .clr_idx (cnt)
        );
    end

    // Victim: resident copy first, then lowest invalid way, then round-robin.
    always_comb begin
        victim = '0;
        use_rr = 1'b0;
        way_we = '0;
        if (|wr_match) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (wr_match[w]) victim = WAY_W'(w);
        end else if (!(&wr_valid)) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!wr_valid[w]) victim = WAY_W'(w);
        end else begin
            victim = rr_ptr[wr_idx];
            use_rr = 1'b1;
        end
        if (fill_en) way_we[victim] = 1'b1;
    end

    // Fill rule guarantees at most one matching way, so an OR-mux suffices.
    assign hit_vec = rd_match & {WAYS{q_en}};
    assign hit     = |hit_vec;

    always_comb begin
        icache_get_inst = '0;
        icache_get_is_c = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            icache_get_inst = icache_get_inst | ({32{hit_vec[w]}} & rd_inst[w]);
            icache_get_is_c = icache_get_is_c | (hit_vec[w] & rd_is_c[w]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (flush_in) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else if (fill_en && use_rr) begin
                        rr_ptr[wr_idx] <= (rr_ptr[wr_idx] == WAY_W'(WAYS - 1)) ?
                                          '0 : rr_ptr[wr_idx] + 1'b1;
                    end
                end
                FLUSH: begin
                    rr_ptr[cnt] <= '0;
                    cnt         <= cnt + 1'b1;
                    if (cnt == IDX_W'(SETS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
